// File: rtl/instr_mem_fetch.sv
// Instruction memory with a run-time loader port and a LATENCY-deep registered
// fetch pipeline using valid/ready handshakes, with fault flagging and flush.
module instr_mem_fetch #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_instr,
  output logic [ADDR_W-1:0]        resp_addr,
  output logic                     resp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_index,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] addr;
    logic              fault;
  } stage_t;

  // Handshake: a request transfers on a cycle where req_valid && req_ready, a
  // response transfers where resp_valid && resp_ready; a presented response
  // holds all its fields until it transfers, is flushed, or reset is applied.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  stage_t            stage_q [LATENCY];
  stage_t            stage_d [LATENCY];
  stage_t            last;
  logic              advance;
  logic              accept;
  logic              req_fault;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_instr;

  assign last      = stage_q[LATENCY-1];
  assign advance   = !last.valid || resp_ready;
  assign req_ready = advance && !flush && !reset;
  assign accept    = req_valid && req_ready;

  assign word_addr = req_addr >> 2;
  assign req_fault = (req_addr[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH));
  assign rd_index  = word_addr[IDX_W-1:0];
  // Faulted fetches bypass the array so out-of-range addresses never alias.
  assign rd_instr  = req_fault ? NOP_WORD : mem_q[rd_index];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (advance) begin
      stage_d[0] = '0;
      if (accept) begin
        stage_d[0].valid = 1'b1;
        stage_d[0].instr = rd_instr;
        stage_d[0].addr  = req_addr;
        stage_d[0].fault = req_fault;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
    // Flush also drops the stage on the outputs, even if it is being taken.
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Loader writes ignore reset and flush; reads above see the pre-write word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_index] <= ld_data;
    end
  end

  assign resp_valid = last.valid;
  assign resp_instr = last.instr;
  assign resp_addr  = last.addr;
  assign resp_fault = last.fault;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: three instances with LATENCY 1..3 sharing the
// loader and reset, checked against a transaction-level memory model.
module tb_instr_mem_fetch;

  localparam int DEPTH = 32;
  localparam logic [31:0] W0 = 32'h8C010000;
  localparam logic [31:0] W1 = 32'h8C020001;
  localparam logic [31:0] W2 = 32'h00221820;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [4:0]  ld_index;
  logic [31:0] ld_data;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        flush      [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_instr [3];
  logic [31:0] resp_addr  [3];
  logic        resp_fault [3];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          sel      = 0;
  logic [31:0] mem_m [DEPTH];
  logic [64:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    instr_mem_fetch #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(k + 1), .NOP_WORD(32'h0)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[k]), .req_ready(req_ready[k]), .req_addr(req_addr[k]),
      .flush(flush[k]),
      .resp_valid(resp_valid[k]), .resp_ready(resp_ready[k]),
      .resp_instr(resp_instr[k]), .resp_addr(resp_addr[k]), .resp_fault(resp_fault[k]),
      .ld_en(ld_en), .ld_index(ld_index), .ld_data(ld_data)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_index = idx; ld_data = data;
    step();
    ld_en = 1'b0;
  endtask

  // Ordered scoreboard for the selected instance: every accepted fetch is
  // predicted from the memory model at acceptance time (before that cycle's load).
  task automatic scoreboard_loop();
    logic [64:0] got, want, hold_out;
    logic [31:0] a;
    logic        hold = 1'b0;
    forever begin
      @(negedge clk);
      got = {resp_fault[sel], resp_addr[sel], resp_instr[sel]};
      if (hold) begin
        n_checks++;
        if (resp_valid[sel] !== 1'b1 || got !== hold_out)
          $display("FAIL sb_hold dut%0d got v=%b %h exp v=1 %h", sel, resp_valid[sel], got, hold_out);
        else n_pass++;
      end
      hold     = resp_valid[sel] && !resp_ready[sel] && !flush[sel] && !reset;
      hold_out = got;
      if (reset || flush[sel]) begin
        exp_q.delete();
      end else if (resp_valid[sel] && resp_ready[sel]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected dut%0d got %h exp none", sel, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) $display("FAIL sb_resp dut%0d got %h exp %h", sel, got, want);
          else n_pass++;
        end
      end
      if (req_valid[sel] && req_ready[sel]) begin
        a = req_addr[sel];
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) exp_q.push_back({1'b1, a, 32'h0});
        else exp_q.push_back({1'b0, a, mem_m[a[6:2]]});
      end
      if (ld_en) mem_m[ld_index] = ld_data;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (req_ready[k] !== 1'b0) $display("FAIL rst_ready_in_reset dut%0d got %b exp 0", k, req_ready[k]);
      else n_pass++;
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({resp_valid[k], resp_instr[k], resp_addr[k], resp_fault[k], req_ready[k]} !== {66'h0, 1'b1})
        $display("FAIL rst_state dut%0d got v=%b i=%h a=%h f=%b r=%b exp 0/0/0/0/1", k,
                 resp_valid[k], resp_instr[k], resp_addr[k], resp_fault[k], req_ready[k]);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words = '{W0, W1, W2};
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = (i < 3);
      req_addr[0]  = 32'(i * 4);
      @(negedge clk);
      if (i < 3) begin
        n_checks++;
        if (req_ready[0] !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, req_ready[0]);
        else n_pass++;
      end
      n_checks++;
      if (i == 0) begin
        if (resp_valid[0] !== 1'b0) $display("FAIL b2b_early got %b exp 0", resp_valid[0]);
        else n_pass++;
      end else if (resp_valid[0] !== 1'b1 || resp_instr[0] !== words[i-1] ||
                   resp_addr[0] !== 32'((i - 1) * 4) || resp_fault[0] !== 1'b0) begin
        $display("FAIL b2b_resp%0d got v=%b i=%h a=%h f=%b exp 1 %h %h 0", i - 1,
                 resp_valid[0], resp_instr[0], resp_addr[0], resp_fault[0], words[i-1], 32'((i - 1) * 4));
      end else n_pass++;
      step();
    end
    req_valid[0] = 1'b0;
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    logic [31:0] instrs [3];
    logic        faults [3];
    addrs  = '{32'h6, 32'h80, 32'h0};
    instrs = '{32'h0, 32'h0, W0};
    faults = '{1'b1, 1'b1, 1'b0};
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = (i < 3);
      if (i < 3) req_addr[0] = addrs[i];
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (resp_valid[0] !== 1'b1 || resp_instr[0] !== instrs[i-1] ||
            resp_addr[0] !== addrs[i-1] || resp_fault[0] !== faults[i-1])
          $display("FAIL fault_resp%0d got v=%b i=%h a=%h f=%b exp 1 %h %h %b", i - 1,
                   resp_valid[0], resp_instr[0], resp_addr[0], resp_fault[0],
                   instrs[i-1], addrs[i-1], faults[i-1]);
        else n_pass++;
      end
      step();
    end
    req_valid[0] = 1'b0;
  endtask

  task automatic test_stall();
    int          n_acc = 0, n_taken = 0, n_stall = 0;
    logic [31:0] hold_addr, hold_instr;
    logic        acc;
    sel = 2;
    resp_ready[2] = 1'b0;
    req_valid[2]  = 1'b1;
    req_addr[2]   = 32'($urandom_range(0, 31) * 4);
    for (int c = 0; c < 100 && n_taken < 6; c++) begin
      @(negedge clk);
      if (resp_valid[2] && !resp_ready[2]) begin
        if (n_stall == 0) begin
          hold_addr  = resp_addr[2];
          hold_instr = resp_instr[2];
        end
        n_checks++;
        if (req_ready[2] !== 1'b0 || resp_addr[2] !== hold_addr || resp_instr[2] !== hold_instr)
          $display("FAIL stall_hold%0d got r=%b a=%h i=%h exp 0 %h %h", n_stall,
                   req_ready[2], resp_addr[2], resp_instr[2], hold_addr, hold_instr);
        else n_pass++;
        n_stall++;
      end
      acc = req_valid[2] && req_ready[2];
      if (acc) n_acc++;
      if (resp_valid[2] && resp_ready[2]) n_taken++;
      step();
      if (acc) req_addr[2] = 32'($urandom_range(0, 31) * 4);
      if (n_acc == 6) req_valid[2] = 1'b0;
      resp_ready[2] = (n_stall >= 4);
    end
    n_checks++;
    if (n_taken != 6 || n_stall != 4 || exp_q.size() != 0)
      $display("FAIL stall_count got taken=%0d stalls=%0d left=%0d exp 6 4 0", n_taken, n_stall, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    sel = 1;
    resp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_addr[1] = 32'h0;
    step();
    req_addr[1] = 32'h4;
    step();
    flush[1] = 1'b1; req_addr[1] = 32'h8;
    @(negedge clk);
    n_checks++;
    if (req_ready[1] !== 1'b0) $display("FAIL flush_ready got %b exp 0", req_ready[1]);
    else n_pass++;
    step();
    flush[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
      $display("FAIL flush_after got v=%b r=%b exp 0 1", resp_valid[1], req_ready[1]);
    else n_pass++;
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b0) $display("FAIL flush_ghost got %b exp 0", resp_valid[1]);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b1 || resp_instr[1] !== W2 || resp_addr[1] !== 32'h8 || resp_fault[1] !== 1'b0)
      $display("FAIL flush_refetch got v=%b i=%h a=%h f=%b exp 1 %h 8 0",
               resp_valid[1], resp_instr[1], resp_addr[1], resp_fault[1], W2);
    else n_pass++;
    step();
  endtask

  task automatic test_read_first();
    logic [31:0] old_word;
    sel = 0;
    old_word = mem_m[5];
    ld_en = 1'b1; ld_index = 5'd5; ld_data = 32'hDEADBEEF;
    req_valid[0] = 1'b1; req_addr[0] = 32'h14;
    step();
    ld_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid[0] !== 1'b1 || resp_instr[0] !== old_word)
      $display("FAIL rdfirst_old got v=%b i=%h exp 1 %h", resp_valid[0], resp_instr[0], old_word);
    else n_pass++;
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid[0] !== 1'b1 || resp_instr[0] !== 32'hDEADBEEF)
      $display("FAIL rdfirst_new got v=%b i=%h exp 1 deadbeef", resp_valid[0], resp_instr[0]);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_stall();
    logic full = 1'b0;
    sel = 2;
    resp_ready[2] = 1'b0; req_valid[2] = 1'b1; req_addr[2] = 32'h10;
    for (int c = 0; c < 20 && !full; c++) begin
      @(negedge clk);
      full = resp_valid[2] && !req_ready[2];
      step();
    end
    n_checks++;
    if (!full) $display("FAIL rststall_fill got 0 exp 1");
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready[2] !== 1'b0) $display("FAIL rststall_ready got %b exp 0", req_ready[2]);
    else n_pass++;
    step();
    reset = 1'b0; req_valid[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({resp_valid[2], resp_instr[2], resp_addr[2], resp_fault[2], req_ready[2]} !== {66'h0, 1'b1})
      $display("FAIL rststall_state got v=%b i=%h a=%h f=%b r=%b exp 0/0/0/0/1",
               resp_valid[2], resp_instr[2], resp_addr[2], resp_fault[2], req_ready[2]);
    else n_pass++;
    step();
    resp_ready[2] = 1'b1; req_valid[2] = 1'b1; req_addr[2] = 32'h14;
    step();
    req_valid[2] = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (resp_valid[2] !== 1'b1 || resp_instr[2] !== 32'hDEADBEEF || resp_addr[2] !== 32'h14)
      $display("FAIL rststall_mem got v=%b i=%h a=%h exp 1 deadbeef 14", resp_valid[2], resp_instr[2], resp_addr[2]);
    else n_pass++;
    step();
  endtask

  task automatic test_random(input int k);
    int r;
    sel = k;
    for (int c = 0; c < 200; c++) begin
      r = int'($urandom_range(0, 9));
      req_valid[k]  = ($urandom_range(0, 3) != 0);
      if (r == 0)      req_addr[k] = 32'($urandom_range(0, 255));
      else if (r == 1) req_addr[k] = $urandom;
      else             req_addr[k] = 32'($urandom_range(0, 31) * 4);
      resp_ready[k] = ($urandom_range(0, 9) < 7);
      flush[k]      = ($urandom_range(0, 19) == 0);
      ld_en         = ($urandom_range(0, 7) == 0);
      ld_index      = 5'($urandom_range(0, 31));
      ld_data       = $urandom;
      step();
    end
    req_valid[k] = 1'b0; flush[k] = 1'b0; ld_en = 1'b0; resp_ready[k] = 1'b1;
    for (int c = 0; c < k + 3; c++) step();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || resp_valid[k] !== 1'b0)
      $display("FAIL random_drain dut%0d got left=%0d v=%b exp 0 0", k, exp_q.size(), resp_valid[k]);
    else n_pass++;
    step();
  endtask

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_index = '0; ld_data = '0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; flush[k] = 1'b0; resp_ready[k] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    fork
      scoreboard_loop();
    join_none
    step();
    test_reset();
    for (int i = 3; i < DEPTH; i++) load_word(5'(i), $urandom);
    load_word(5'd0, W0);
    load_word(5'd1, W1);
    load_word(5'd2, W2);
    test_back_to_back();
    test_fault();
    test_stall();
    test_flush();
    test_read_first();
    test_reset_stall();
    for (int k = 0; k < 3; k++) test_random(k);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised instruction memory with a registered, pipelined fetch port for the pipelined MIPS core.
- Depth, data width and read latency are configurable.
- Fetch uses a valid/ready request/response handshake.
- A loader write port fills the memory at run time.
- Misaligned or out-of-range fetches are flagged with a fault bit, not silently aliased.
- A flush input lets the fetch stage drop in-flight fetches on a taken branch or jump.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, byte-address width of req_addr
DEPTH, 32, number of instruction words; power of two, 2..4096
LATENCY, 1, cycles from request acceptance to response; legal 1..4
NOP_WORD, 32'h00000000, instruction returned on a faulted fetch

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  ADDR_W  byte address of the instruction
flush  in  1  kill all in-flight fetches this cycle
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response when resp_valid && resp_ready
resp_instr  out  DATA_W  fetched instruction
resp_addr  out  ADDR_W  byte address the response belongs to
resp_fault  out  1  fetch was misaligned or out of range
ld_en  in  1  loader write strobe
ld_index  in  $clog2(DEPTH)  word index to write
ld_data  in  DATA_W  word to write

Behaviour:
- Word index = req_addr >> 2.
- Fault = (req_addr[1:0] != 0) || (req_addr >> 2) >= DEPTH. A faulted fetch returns NOP_WORD with resp_fault=1, never reads the array, and consumes a pipeline slot like a normal fetch.
- Pipeline: LATENCY stages, each holding {valid, instr, addr, fault}. The last stage drives the resp_* outputs.
- advance = !last_valid || resp_ready. While advance=0 every stage holds.
- req_ready = advance && !flush && !reset, computed combinationally.
- Memory read is sampled in the acceptance cycle T. With no stall, resp_valid=1 from edge T+LATENCY. A full pipeline sustains 1 fetch/cycle.
- Responses are delivered in order. Outputs stay stable while resp_valid && !resp_ready.
- flush=1: every stage's valid clears at the next edge, including the stage presented on the outputs. No request is accepted that cycle. resp_valid=0 in the following cycle. flush overrides advance.
- Loader:
  - ld_en=1 writes ld_data to mem[ld_index] at the edge.
  - Writes are independent of handshake state, flush and reset; the array is never cleared by reset.
  - Same-cycle read and write of the same index returns the OLD word (read-first). A fetch accepted in the following cycle returns the new word.
- Array contents at time zero are all zero.
- Reset (sync, any time, including mid-stall):
  - All stage valids clear; resp_valid=0, resp_instr=0, resp_addr=0, resp_fault=0 after the edge.
  - In-flight fetches are lost.
  - req_ready=0 during the reset cycle and 1 in the first cycle after reset, since the pipeline is then empty.
- Simultaneous flush and resp_ready: the flush wins. The response on the outputs in that cycle is counted as taken and is not re-presented.

Test Plan:
- Load words 0x8C010000, 0x8C020001, 0x00221820 at indices 0..2. LATENCY=1. Back-to-back requests to addresses 0, 4, 8 -> responses one per cycle, at T+1, T+2, T+3, with those words, resp_fault=0, resp_addr 0/4/8.
- LATENCY=3, resp_ready held 0 for 4 cycles after the first response -> req_ready=0 while stalled, resp_instr/resp_addr stable. After release, the remaining responses arrive in order with none lost or duplicated.
- Request address 0x6 (misaligned), then 0x80 with DEPTH=32 (out of range) -> both responses carry resp_fault=1 and resp_instr=0x00000000. A following fetch of address 0 returns the correct word with fault=0.
- LATENCY=2, two fetches in flight, flush asserted with req_valid=1 -> resp_valid=0 the next cycle, req_ready=0 during the flush, no flushed response ever appears. A request after the flush returns correctly at +2.
- ld_en writes 0xDEADBEEF to index 5 in the same cycle a fetch of address 0x14 is accepted -> the response carries the old word. A refetch next cycle returns 0xDEADBEEF.
- Assert reset while the pipeline is full and stalled -> resp_valid=0 and all resp_* outputs 0 after the edge, req_ready=1 the cycle after reset. Memory contents are retained, checked by refetching index 5 and getting 0xDEADBEEF.
